// File: rtl/intr_pend_pkg.sv
// Shared types and helpers for the interrupt pending block.
// The onehot encoder is meant to be reused by other arbiters.
package intr_pend_pkg;

  localparam int unsigned OH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    PRESENT = 2'd2,
    CLEAR   = 2'd3
  } state_e;

  function automatic logic [4:0] onehot2idx(
    input logic [OH_MAX-1:0] oh
  );
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pri8.sv
// One-hot highest-priority selector.
// Bit N-1 wins over all lower bits.
module pri8 #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  logic found;

  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && i_req[i]) begin
        o_grant[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_pend.sv
// Sticky pending register with mask, priority pick and
// an acknowledge sequencer holding the grant until served.
module intr_pend
  import intr_pend_pkg::*;
#(
  parameter int N  = 16,
  parameter int VW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic          i_ack,
  output logic          o_irq,
  output logic [N-1:0]  o_grant,
  output logic [VW-1:0] o_vec,
  output logic [N-1:0]  o_pend,
  output logic          o_busy
);

  state_e        state_q;
  logic [N-1:0]  pend_q;
  logic [N-1:0]  pend_d;
  logic [N-1:0]  grant_q;
  logic [VW-1:0] vec_q;
  logic          irq_q;

  logic [N-1:0]  masked;
  logic [N-1:0]  pick;
  logic [N-1:0]  clr;
  logic [VW-1:0] pick_idx;
  logic          ack_ok;

  assign masked   = pend_q & i_mask;
  assign ack_ok   = (state_q == PRESENT) && i_ack;
  assign clr      = ack_ok ? grant_q : '0;
  // Set wins: a fresh request on the served bit survives.
  assign pend_d   = (pend_q & ~clr) | i_req;
  assign pick_idx = VW'(onehot2idx(OH_MAX'(pick)));

  pri8 #(.N(N)) u_pri (
    .i_req   (masked),
    .o_grant (pick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      grant_q <= '0;
      vec_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        IDLE: begin
          if (|masked) state_q <= SELECT;
        end
        SELECT: begin
          if (|masked) begin
            grant_q <= pick;
            vec_q   <= pick_idx;
            irq_q   <= 1'b1;
            state_q <= PRESENT;
          end else begin
            state_q <= IDLE;
          end
        end
        PRESENT: begin
          if (i_ack) begin
            grant_q <= '0;
            vec_q   <= '0;
            irq_q   <= 1'b0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_irq   = irq_q;
  assign o_grant = grant_q;
  assign o_vec   = vec_q;
  assign o_pend  = pend_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_intr_pend.sv
// Directed bench for intr_pend with a behavioural
// reference model compared on every cycle.
module tb_intr_pend;

  localparam int N  = 16;
  localparam int VW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic          ack;
  logic          irq;
  logic [N-1:0]  grant;
  logic [VW-1:0] vec;
  logic [N-1:0]  pend;
  logic          busy;

  int checks = 0;
  int errors = 0;

  intr_pend #(.N(N), .VW(VW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_mask  (mask),
    .i_ack   (ack),
    .o_irq   (irq),
    .o_grant (grant),
    .o_vec   (vec),
    .o_pend  (pend),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 choosing,
  // 2 holding a committed grant, 3 settling.
  int          m_phase = 0;
  int          m_gidx  = -1;
  logic [N-1:0] m_pend = '0;
  bit          started = 0;

  function automatic int top_bit(input logic [N-1:0] v);
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] mset;
    logic [N-1:0] served;
    started = 1;
    if (!rst) begin
      m_phase = 0;
      m_gidx  = -1;
      m_pend  = '0;
    end else begin
      mset   = m_pend & mask;
      served = '0;
      if (m_phase == 2 && ack)
        served[m_gidx] = 1'b1;
      m_pend = (m_pend & ~served) | req;
      case (m_phase)
        0: if (mset != 0) m_phase = 1;
        1: begin
          if (mset != 0) begin
            m_gidx  = top_bit(mset);
            m_phase = 2;
          end else begin
            m_phase = 0;
          end
        end
        2: if (ack) begin
          m_gidx  = -1;
          m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    if (started) begin
      eg = '0;
      if (m_gidx >= 0) eg[m_gidx] = 1'b1;
      chk("m_irq", 32'(irq), 32'(m_gidx >= 0));
      chk("m_grant", 32'(grant), 32'(eg));
      chk("m_vec", 32'(vec),
          (m_gidx >= 0) ? 32'(m_gidx) : 32'd0);
      chk("m_pend", 32'(pend), 32'(m_pend));
      chk("m_busy", 32'(busy), 32'(m_phase != 0));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [N-1:0] v);
    req = v;
    step(1);
    req = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  task automatic held(
    input string        name,
    input logic [N-1:0] g,
    input int           v
  );
    chk({name, "_irq"}, 32'(irq), 32'd1);
    chk({name, "_grant"}, 32'(grant), 32'(g));
    chk({name, "_vec"}, 32'(vec), 32'(v));
  endtask

  initial begin
    rst  = 1'b0;
    req  = '1;
    mask = '1;
    ack  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_pend", 32'(pend), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_vec", 32'(vec), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b1;
    req = '0;
    step(2);

    // single request
    pulse_req(16'h0010);
    chk("s_pend", 32'(pend), 32'h0010);
    chk("s_irq0", 32'(irq), 32'd0);
    step(1);
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_irq1", 32'(irq), 32'd0);
    step(1);
    held("s", 16'h0010, 4);
    step(2);
    held("s_hold", 16'h0010, 4);
    do_ack();
    chk("s_ack_irq", 32'(irq), 32'd0);
    chk("s_ack_pend", 32'(pend), 32'd0);
    step(2);

    // stray ack in idle
    ack = 1'b1;
    step(2);
    ack = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_pend", 32'(pend), 32'd0);
    chk("stray_irq", 32'(irq), 32'd0);

    // priority, no preemption
    pulse_req(16'h0081);
    step(2);
    held("p", 16'h0080, 7);
    pulse_req(16'h8000);
    held("p_nopre", 16'h0080, 7);
    chk("p_pend", 32'(pend), 32'h8081);
    do_ack();
    chk("p_pend2", 32'(pend), 32'h8001);
    step(3);
    held("p_hi", 16'h8000, 15);
    do_ack();
    step(3);
    held("p_lo", 16'h0001, 0);
    do_ack();
    step(2);

    // mask
    mask = 16'h00FF;
    pulse_req(16'h0300);
    step(3);
    chk("m_noirq", 32'(irq), 32'd0);
    chk("m_idle", 32'(busy), 32'd0);
    chk("m_pendv", 32'(pend), 32'h0300);
    mask = 16'hFFFF;
    step(2);
    held("m_on", 16'h0200, 9);
    mask = 16'hFDFF;
    step(2);
    held("m_commit", 16'h0200, 9);
    do_ack();
    chk("m_pend3", 32'(pend), 32'h0100);
    step(3);
    held("m_next", 16'h0100, 8);
    mask = 16'hFFFF;
    do_ack();
    step(2);

    // set wins over clear
    pulse_req(16'h0004);
    step(2);
    held("c", 16'h0004, 2);
    ack = 1'b1;
    req = 16'h0004;
    step(1);
    ack = 1'b0;
    req = '0;
    chk("c_pend", 32'(pend), 32'h0004);
    chk("c_irq0", 32'(irq), 32'd0);
    step(2);
    chk("c_gap", 32'(irq), 32'd0);
    step(1);
    held("c_regrant", 16'h0004, 2);
    do_ack();
    step(2);

    // reset mid-present
    pulse_req(16'h0021);
    step(2);
    held("r", 16'h0020, 5);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("r_irq", 32'(irq), 32'd0);
    chk("r_grant", 32'(grant), 32'd0);
    chk("r_vec", 32'(vec), 32'd0);
    chk("r_pend", 32'(pend), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    pulse_req(16'h0002);
    step(2);
    held("r_resume", 16'h0002, 1);
    do_ack();
    step(3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_pend.md
Name: intr_pend

Overview:
- Sticky pending-request register with a mask and an acknowledge sequencer.
- Sits directly upstream of the one-hot highest-priority selector (pri8).
  - Collects request pulses from channels/units.
  - Presents the masked pending set to the selector.
  - Holds the winning grant stable, as one-hot plus binary index, until the microcode/consumer acknowledges it.
- Acknowledge clears the served bit. Other pending requests are never lost.

Parameters:
N, 16, number of request lines; bit N-1 is highest priority
VW, $clog2(N), width of o_vec

Ports:
i_clk  input  1  clock; one clock domain
i_rst  input  1  reset: synchronous and active-low (0 = reset, sampled on i_clk rising edge)
i_req  input  N  request pulses/levels; any cycle high sets the pending bit
i_mask  input  N  1 = request line enabled for selection
i_ack  input  1  consumer acknowledge of presented grant
o_irq  output  1  grant valid
o_grant  output  N  one-hot grant; 0 when o_irq=0
o_vec  output  VW  binary index of o_grant; 0 when o_irq=0
o_pend  output  N  raw pending register (unmasked), for status reads
o_busy  output  1  state != IDLE

Behaviour:
- Reset (i_rst=0 at an edge): pend=0, state=IDLE, o_irq=0, o_grant=0, o_vec=0, o_busy=0. Reset overrides all other inputs, including mid-PRESENT.
- Pending update every edge: pend <= (pend & ~clr) | i_req.
  - clr is the one-hot grant only on an accepted ack; otherwise 0.
  - A set and a clear of the same bit in the same cycle leave the bit set (set wins; the new request is kept).
- Priority: highest set bit of (pend & i_mask) wins (bit N-1 highest). Selection goes through the pri8 sub-module.
- FSM states: IDLE, SELECT, PRESENT, CLEAR.
  - IDLE: if |(pend & i_mask) then -> SELECT; else stay.
  - SELECT: register o_grant = pri(pend & i_mask), o_vec = index, o_irq=1; -> PRESENT.
    - If the masked set became 0 this cycle (mask dropped): -> IDLE, no grant.
  - PRESENT: o_irq/o_grant/o_vec held stable regardless of i_req/i_mask changes, including masking of the granted bit (grant is committed).
    - On i_ack=1: clr=o_grant; o_irq, o_grant, o_vec go to 0 after the edge; -> CLEAR.
  - CLEAR: one dead cycle so the cleared pend is visible before reselection; -> IDLE.
- i_ack outside PRESENT is ignored (no clear, no state change).
- Latency:
  - i_req sampled at edge k: o_pend bit set after k, SELECT after k+1, o_irq=1 after k+2.
  - i_ack sampled at edge m: o_irq=0 after m, IDLE after m+1, next o_irq earliest after m+3.
- Higher-priority requests arriving during PRESENT do not preempt. They are served on the next selection.
- The selection path is combinational through pri8 only in SELECT; all outputs are registered.
- o_vec encoding: o_vec = i where o_grant[i]=1. An all-zero grant encodes to 0.

Decomposition:
- Shared package:
  - state enum (IDLE=2'd0, SELECT=2'd1, PRESENT=2'd2, CLEAR=2'd3);
  - onehot-to-index function, reusable by other arbiters.
- Sub-module: one instance of pri8 (N passed through) for the masked-pending priority pick.
- The onehot-to-index encoder stays as the package function, not a module.

Test Plan:
- Reset: drive i_req=16'hFFFF with i_rst=0 for 3 cycles -> o_pend=0, o_irq=0, o_grant=0, o_vec=0, o_busy=0 throughout.
- Single request: i_mask=16'hFFFF, i_req=16'h0010 for one cycle at edge k -> o_irq=1, o_grant=16'h0010, o_vec=4 after k+2. Outputs hold until i_ack, then o_pend=0 and o_irq=0.
- Priority and no preemption:
  - pend=16'h0081 -> grant 16'h0080, o_vec=7.
  - During PRESENT, pulse i_req=16'h8000 -> grant unchanged.
  - After ack, next grant is 16'h8000 (o_vec=15), then 16'h0001 (o_vec=0).
- Mask:
  - i_mask=16'h00FF, pend=16'h0300 -> no o_irq, o_pend=16'h0300.
  - Set i_mask=16'hFFFF -> grant 16'h0200.
  - Clear mask bit 9 during PRESENT -> grant held until ack.
- Set-wins collision: in PRESENT with grant 16'h0004, assert i_ack and i_req=16'h0004 together -> o_pend bit 2 stays 1, and the block re-grants 16'h0004 (o_irq again at m+3).
- Reset mid-operation and stray ack:
  - i_ack pulses in IDLE with pend=0 -> no effect.
  - i_rst=0 during PRESENT -> all outputs 0 next cycle, pend cleared, then normal operation resumes.
